// File: rtl/router_pkg.sv
// router_pkg: state encodings and address constants shared by the router control logic
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_fsm.sv
// router_fsm: control FSM of the 1x3 packet router (address decode, load sequencing, full stall)
module router_fsm
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       packet_valid,
    input  logic [1:0] datain,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       ld_state,
    output logic       laf_state,
    output logic       lfd_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
);

    state_t     state;
    logic [1:0] addr_reg;
    logic [3:0] empty_v;
    logic [3:0] srst_v;
    logic       addr_ok;

    // bit 3 pads the invalid address so indexing by a 2-bit address never leaves the vector
    assign empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign srst_v  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign addr_ok = packet_valid && (datain != ADDR_INVALID);

    // state and latched destination; conditions are tested both ways so unknown inputs hold state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            addr_reg <= 2'b00;
        end else begin
            if (state == DECODE_ADDRESS && addr_ok) addr_reg <= datain;
            if (srst_v[addr_reg]) state <= DECODE_ADDRESS;
            else begin
                case (state)
                    DECODE_ADDRESS: begin
                        if (addr_ok) begin
                            if (empty_v[datain]) state <= LOAD_FIRST_DATA;
                            else if (!empty_v[datain]) state <= WAIT_TILL_EMPTY;
                        end
                    end
                    WAIT_TILL_EMPTY: if (empty_v[addr_reg]) state <= LOAD_FIRST_DATA;
                    LOAD_FIRST_DATA: state <= LOAD_DATA;
                    LOAD_DATA: begin
                        if (fifo_full) state <= FIFO_FULL_STATE;
                        else if (!fifo_full && !packet_valid) state <= LOAD_PARITY;
                    end
                    FIFO_FULL_STATE: if (!fifo_full) state <= LOAD_AFTER_FULL;
                    LOAD_AFTER_FULL: begin
                        if (parity_done) state <= DECODE_ADDRESS;
                        else if (!parity_done && low_packet_valid) state <= LOAD_PARITY;
                        else if (!parity_done && !low_packet_valid) state <= LOAD_DATA;
                    end
                    LOAD_PARITY: state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR: begin
                        if (fifo_full) state <= FIFO_FULL_STATE;
                        else if (!fifo_full) state <= DECODE_ADDRESS;
                    end
                    default: state <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    assign detect_add    = state == DECODE_ADDRESS;
    assign lfd_state     = state == LOAD_FIRST_DATA;
    assign ld_state      = state == LOAD_DATA;
    assign full_state    = state == FIFO_FULL_STATE;
    assign laf_state     = state == LOAD_AFTER_FULL;
    assign rst_int_reg   = state == CHECK_PARITY_ERROR;
    assign write_enb_reg = ld_state || laf_state || state == LOAD_PARITY;
    assign busy          = !(detect_add || ld_state);

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed vector table plus reset corner sequences for router_fsm
module tb_router_fsm;

    localparam logic [7:0] DA  = 8'b0100_0000;
    localparam logic [7:0] LFD = 8'b0000_1001;
    localparam logic [7:0] LD  = 8'b1010_0000;
    localparam logic [7:0] LP  = 8'b1000_0001;
    localparam logic [7:0] FFS = 8'b0000_0101;
    localparam logic [7:0] LAF = 8'b1001_0001;
    localparam logic [7:0] WTE = 8'b0000_0001;
    localparam logic [7:0] CPE = 8'b0000_0011;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       packet_valid = 1'b0;
    logic [1:0] datain = 2'b00;
    logic       fifo_full = 1'b0;
    logic [2:0] empty = 3'b111;
    logic [2:0] srst = 3'b000;
    logic       parity_done = 1'b0;
    logic       low_packet_valid = 1'b0;
    logic       write_enb_reg, detect_add, ld_state, laf_state;
    logic       lfd_state, full_state, rst_int_reg, busy;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       pv;
        logic [1:0] d;
        logic       full;
        logic [2:0] e;
        logic [2:0] s;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    router_fsm dut (
        .clk(clk), .resetn(resetn), .packet_valid(packet_valid), .datain(datain),
        .fifo_full(fifo_full), .fifo_empty_0(empty[0]), .fifo_empty_1(empty[1]),
        .fifo_empty_2(empty[2]), .soft_reset_0(srst[0]), .soft_reset_1(srst[1]),
        .soft_reset_2(srst[2]), .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .write_enb_reg(write_enb_reg), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .lfd_state(lfd_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    assign outs = {write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state, rst_int_reg, busy};

    task automatic add(input logic pv, input logic [1:0] d, input logic full, input logic [2:0] e,
                       input logic [2:0] s, input logic pd, input logic lpv, input logic [7:0] exp);
        vecs.push_back('{pv, d, full, e, s, pd, lpv, exp});
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s: outputs %b, expected %b", name, outs, exp);
        end
    endtask

    initial begin
        // normal packet to FIFO 0
        add(1, 0, 0, 3'b111, 0, 0, 0, LFD);
        add(1, 0, 0, 3'b111, 0, 0, 0, LD);
        add(1, 0, 0, 3'b111, 0, 0, 0, LD);
        add(0, 0, 0, 3'b111, 0, 0, 0, LP);
        add(0, 0, 0, 3'b111, 0, 0, 0, CPE);
        add(0, 0, 0, 3'b111, 0, 0, 0, DA);
        // full stall, leave via low_packet_valid
        add(1, 0, 0, 3'b111, 0, 0, 0, LFD);
        add(1, 0, 0, 3'b111, 0, 0, 0, LD);
        add(1, 0, 1, 3'b111, 0, 0, 0, FFS);
        add(1, 0, 1, 3'b111, 0, 0, 0, FFS);
        add(1, 0, 0, 3'b111, 0, 0, 0, LAF);
        add(0, 0, 0, 3'b111, 0, 0, 1, LP);
        add(0, 0, 0, 3'b111, 0, 0, 0, CPE);
        add(0, 0, 0, 3'b111, 0, 0, 0, DA);
        // LAF back to LD, CPE full path, LAF parity_done exit (FIFO 2)
        add(1, 2, 0, 3'b111, 0, 0, 0, LFD);
        add(1, 2, 0, 3'b111, 0, 0, 0, LD);
        add(1, 2, 1, 3'b111, 0, 0, 0, FFS);
        add(1, 2, 0, 3'b111, 0, 0, 0, LAF);
        add(1, 2, 0, 3'b111, 0, 0, 0, LD);
        add(0, 2, 0, 3'b111, 0, 0, 0, LP);
        add(0, 2, 0, 3'b111, 0, 0, 0, CPE);
        add(0, 2, 1, 3'b111, 0, 0, 0, FFS);
        add(0, 2, 0, 3'b111, 0, 0, 0, LAF);
        add(0, 2, 0, 3'b111, 0, 1, 0, DA);
        // wait for FIFO 1 to drain
        add(1, 1, 0, 3'b101, 0, 0, 0, WTE);
        add(1, 1, 0, 3'b101, 0, 0, 0, WTE);
        add(1, 1, 0, 3'b101, 0, 0, 0, WTE);
        add(1, 1, 0, 3'b111, 0, 0, 0, LFD);
        add(1, 1, 0, 3'b111, 0, 0, 0, LD);
        // soft reset only honoured for the addressed FIFO
        add(1, 1, 0, 3'b111, 3'b001, 0, 0, LD);
        add(1, 1, 0, 3'b111, 3'b010, 0, 0, DA);
        add(1, 0, 0, 3'b111, 0, 0, 0, LFD);
        add(1, 0, 0, 3'b111, 0, 0, 0, LD);
        add(1, 0, 0, 3'b111, 3'b010, 0, 0, LD);
        add(1, 0, 0, 3'b111, 3'b001, 0, 0, DA);
        // invalid address holds DECODE
        add(1, 3, 0, 3'b111, 0, 0, 0, DA);
        add(1, 3, 0, 3'b111, 0, 0, 0, DA);
        // soft reset out of WAIT_TILL_EMPTY
        add(1, 2, 0, 3'b011, 0, 0, 0, WTE);
        add(1, 2, 0, 3'b011, 3'b100, 0, 0, DA);
        add(1, 1, 0, 3'b111, 0, 0, 0, LFD);
        add(1, 1, 0, 3'b111, 0, 0, 0, LD);

        #1 check("reset_async", DA);
        repeat (2) @(posedge clk);
        #1 check("reset_state", DA);
        resetn = 1'b1;
        foreach (vecs[i]) begin
            packet_valid     = vecs[i].pv;
            datain           = vecs[i].d;
            fifo_full        = vecs[i].full;
            empty            = vecs[i].e;
            srst             = vecs[i].s;
            parity_done      = vecs[i].pd;
            low_packet_valid = vecs[i].lpv;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), vecs[i].exp);
        end
        // asynchronous reset from LOAD_DATA takes effect without a clock edge
        check("pre_async_ld", LD);
        #2 resetn = 1'b0;
        #1 check("async_reset_mid_ld", DA);
        @(posedge clk);
        #1 check("reset_held", DA);
        resetn = 1'b1;
        packet_valid = 1'b1;
        datain = 2'b11;
        @(posedge clk);
        #1 check("invalid_after_reset", DA);
        datain = 2'b00;
        @(posedge clk);
        #1 check("valid_after_reset", LFD);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
